// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets (addr[3:2]), STATUS bit positions, frame size and
// serialiser state encoding.
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVERFLOW  = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser.
// Ports: clk, rst_n (async, active-low), push/din enqueue, pop dequeue,
// dout = current head (combinational), full, empty, count (0..DEPTH).
// A push while full is accepted only if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Ports: clk, rst_n (async, active-low); bus side sel/addr/wdata/wenable
// with combinational, side-effect-free rdata (0 when !sel); serial output
// tx (idle high); irq = FIFO empty and serialiser idle.
// Registers (addr[3:2]): 0 TXDATA (write pushes), 1 STATUS, 2 DIVISOR.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = $clog2(FRAME_BITS);

  logic [1:0]       reg_idx;
  logic             lane0_wr;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [7:0]       head;
  logic [CW-1:0]    count;
  logic [3:0]       count_sat;
  logic             overflow;
  logic [DIV_W-1:0] divisor;
  logic [31:0]      lane_mask;

  tx_state_e        state, state_n;
  logic [DIV_W-1:0] baud_cnt, baud_n;
  logic [DIV_W-1:0] div_l, div_n;
  logic [IW-1:0]    bit_idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_q, tx_n;
  logic             baud_done;
  logic             load;

  assign reg_idx   = addr[3:2];
  assign lane0_wr  = sel && wenable[0];
  assign push      = lane0_wr && (reg_idx == REG_TXDATA);
  assign lane_mask = {{8{wenable[3]}}, {8{wenable[2]}}, {8{wenable[1]}}, {8{wenable[0]}}};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A drop only happens when full and the serialiser is not popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (lane0_wr && reg_idx == REG_STATUS && wdata[ST_OVERFLOW]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DIV_W'(DEFAULT_DIV);
    end else if (sel && reg_idx == REG_DIVISOR) begin
      divisor <= (divisor & ~lane_mask[DIV_W-1:0]) | (wdata[DIV_W-1:0] & lane_mask[DIV_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_l    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      div_l    <= div_n;
      bit_idx  <= idx_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  assign baud_done = (baud_cnt == div_l);

  // tx is registered, so each branch sets the level for the coming bit.
  // Frame loads (from IDLE or at the end of STOP) share one path.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    div_n   = div_l;
    idx_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        load = !empty;
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          idx_n   = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == IW'(FRAME_BITS - 1)) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = shift >> 1;
            idx_n   = bit_idx + IW'(1);
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud_cnt + DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = IDLE;
          load    = !empty;
        end else begin
          baud_n = baud_cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_n = head;
      div_n   = divisor;
      baud_n  = '0;
      tx_n    = 1'b0;
      state_n = START;
    end
  end

  assign tx  = tx_q;
  assign irq = empty && (state == IDLE);

  assign count_sat = (32'(count) > 32'd15) ? 4'hF : 4'(count);

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        REG_STATUS: begin
          rdata[ST_BUSY]                     = (state != IDLE);
          rdata[ST_FULL]                     = full;
          rdata[ST_EMPTY]                    = empty;
          rdata[ST_OVERFLOW]                 = overflow;
          rdata[ST_COUNT_LSB +: 4]           = count_sat;
        end
        REG_DIVISOR: rdata[DIV_W-1:0] = divisor;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wenable = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DEFAULT_DIV(433)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .addr    (addr),
    .wdata   (wdata),
    .wenable (wenable),
    .rdata   (rdata),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus a frame timer t in 0..10*(D+1)-1.
  logic [7:0]  q[$];
  bit          m_ovf;
  logic [15:0] m_div;
  bit          active;
  int          t;
  logic [7:0]  cur;
  int          cur_div;

  task automatic model_reset();
    q.delete();
    m_ovf   = 0;
    m_div   = 16'd433;
    active  = 0;
    t       = 0;
    cur     = '0;
    cur_div = 0;
  endtask

  function automatic logic exp_tx();
    int k;
    if (!active) return 1'b1;
    k = t / (cur_div + 1);
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rdata(logic s, logic [3:0] a);
    logic [31:0] r;
    int c;
    r = '0;
    if (!s) return r;
    case (a[3:2])
      2'd1: begin
        c = (q.size() > 15) ? 15 : q.size();
        r[0]   = active;
        r[1]   = (q.size() == DEPTH);
        r[2]   = (q.size() == 0);
        r[3]   = m_ovf;
        r[7:4] = 4'(c);
      end
      2'd2: r[15:0] = m_div;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_edge(logic s, logic [3:0] a, logic [31:0] wd, logic [3:0] we);
    bit push_req, pop_now, finish, accept;
    int last;
    last     = 10 * (cur_div + 1) - 1;
    push_req = s && we[0] && (a[3:2] == 2'd0);
    finish   = active && (t == last);
    pop_now  = (q.size() > 0) && (!active || finish);
    accept   = push_req && ((q.size() < DEPTH) || pop_now);
    if (push_req && !accept) m_ovf = 1;
    if (s && we[0] && a[3:2] == 2'd1 && wd[3]) m_ovf = 0;
    if (pop_now) begin
      cur     = q.pop_front();
      cur_div = int'(m_div);
      active  = 1;
      t       = 0;
    end else if (finish) begin
      active = 0;
    end else if (active) begin
      t++;
    end
    if (accept) q.push_back(wd[7:0]);
    if (s && a[3:2] == 2'd2) begin
      if (we[0]) m_div[7:0]  = wd[7:0];
      if (we[1]) m_div[15:8] = wd[15:8];
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one bus cycle and checks against the model.
  task automatic cycle(input logic s, input logic [3:0] a, input logic [31:0] wd,
                       input logic [3:0] we, output logic [31:0] rd);
    sel = s; addr = a; wdata = wd; wenable = we;
    #1;
    rd = rdata;
    check("rdata", rdata, exp_rdata(s, a));
    @(posedge clk);
    model_edge(s, a, wd, we);
    #1;
    check("tx", 32'(tx), 32'(exp_tx()));
    check("irq", 32'(irq), 32'((q.size() == 0) && !active));
  endtask

  task automatic idle(output logic [31:0] rd);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, rd);
  endtask

  task automatic wait_idle(string name, int bound);
    logic [31:0] rd;
    for (int n = 0; n < bound; n++) begin
      if (irq) break;
      idle(rd);
    end
    check(name, 32'(irq), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        s;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [3:0]  we;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    int first, rise;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd1);

    // Post-reset register table (also verifies stray writes do not push).
    vecs.push_back('{"status_rst",   1'b1, 4'h4, 32'h0,        4'h0, 32'h0000_0004});
    vecs.push_back('{"div_rst",      1'b1, 4'h8, 32'h0,        4'h0, 32'd433});
    vecs.push_back('{"txdata_rd",    1'b1, 4'h0, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{"reserved_rd",  1'b1, 4'hC, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{"nosel_rd",     1'b0, 4'h4, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{"status_alias", 1'b1, 4'h7, 32'h0,        4'h0, 32'h0000_0004});
    vecs.push_back('{"div_alias",    1'b1, 4'h9, 32'h0,        4'h0, 32'd433});
    vecs.push_back('{"reserved_wr",  1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vecs.push_back('{"div_after_rsv",1'b1, 4'h8, 32'h0,        4'h0, 32'd433});
    vecs.push_back('{"nosel_push",   1'b0, 4'h0, 32'h55,       4'h1, 32'h0});
    vecs.push_back('{"status_nosel", 1'b1, 4'h4, 32'h0,        4'h0, 32'h0000_0004});
    vecs.push_back('{"push_no_lane0",1'b1, 4'h0, 32'h66,       4'hE, 32'h0});
    vecs.push_back('{"status_nolane",1'b1, 4'h4, 32'h0,        4'h0, 32'h0000_0004});
    foreach (vecs[i]) begin
      cycle(vecs[i].s, vecs[i].a, vecs[i].wd, vecs[i].we, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // Single frame 0xA5 at DIV=3: 40 cycles from first low bit to irq.
    cycle(1'b1, 4'h8, 32'd3, 4'b0011, rd);
    cycle(1'b1, 4'h0, 32'hA5, 4'b0001, rd);
    first = -1; rise = -1;
    for (int n = 1; n <= 100; n++) begin
      idle(rd);
      if (first < 0 && tx == 1'b0) first = n;
      if (first >= 0 && irq == 1'b1) begin
        rise = n;
        break;
      end
    end
    check("frame_len", 32'(rise - first), 32'd40);
    check("first_low", 32'(first), 32'd1);

    // Back-to-back frames; reading TXDATA must not pop.
    cycle(1'b1, 4'h0, 32'h01, 4'b0001, rd);
    cycle(1'b1, 4'h0, 32'h02, 4'b0001, rd);
    cycle(1'b1, 4'h0, 32'h03, 4'b0001, rd);
    cycle(1'b1, 4'h4, 32'h0, 4'h0, rd);
    check("b2b_status", rd, 32'h0000_0021);
    cycle(1'b1, 4'h0, 32'h0, 4'h0, rd);
    cycle(1'b1, 4'h4, 32'h0, 4'h0, rd);
    check("txdata_rd_nopop", rd, 32'h0000_0021);
    wait_idle("b2b_done", 200);

    // Fill: 9 pushes fit (first pops), 10th overflows, then clear.
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'h0, 32'(8'h30 + i), 4'b0001, rd);
    cycle(1'b1, 4'h4, 32'h0, 4'h0, rd);
    check("ovf_status", rd, 32'h0000_008B);
    cycle(1'b1, 4'h4, 32'h8, 4'b0001, rd);
    cycle(1'b1, 4'h4, 32'h0, 4'h0, rd);
    check("ovf_cleared", rd, 32'h0000_0083);
    wait_idle("fill_done", 500);

    // Divisor change mid-frame applies from the next frame.
    cycle(1'b1, 4'h0, 32'h3C, 4'b0001, rd);
    cycle(1'b1, 4'h0, 32'h96, 4'b0001, rd);
    repeat (10) idle(rd);
    cycle(1'b1, 4'h8, 32'd1, 4'b0011, rd);
    wait_idle("divchg_done", 200);

    // Reset mid-frame.
    cycle(1'b1, 4'h8, 32'd3, 4'b0011, rd);
    cycle(1'b1, 4'h0, 32'hF0, 4'b0001, rd);
    cycle(1'b1, 4'h0, 32'h0F, 4'b0001, rd);
    idle(rd);
    idle(rd);
    check("pre_reset_tx", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'h4, 32'h0, 4'h0, rd);
    check("rst_status", rd, 32'h0000_0004);
    cycle(1'b1, 4'h8, 32'h0, 4'h0, rd);
    check("rst_div", rd, 32'd433);

    // Randomized traffic with small divisors (including 0).
    cycle(1'b1, 4'h8, 32'd0, 4'b0011, rd);
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3:
          cycle(1'b1, 4'(($urandom_range(0, 3) << 2) & 4'h0) | 4'($urandom_range(0, 3)),
                $urandom, 4'($urandom_range(0, 15)) | 4'(($urandom_range(0, 3) != 0) ? 1 : 0), rd);
        4: cycle(1'b1, 4'h8 | 4'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), rd);
        5: cycle(1'b1, 4'h4, $urandom, 4'($urandom_range(0, 15)), rd);
        6: cycle(1'b1, 4'($urandom_range(0, 15)), 32'h0, 4'h0, rd);
        7: cycle(1'b0, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), rd);
        default: idle(rd);
      endcase
    end
    wait_idle("random_done", 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU data/instruction bus, downstream of the multi-cycle core's mem_addr/mem_wdata/mem_wenable/mem_rdata port. An external address decoder asserts sel for this block's 16-byte window. CPU stores queue bytes into a TX FIFO, and an 8N1 serialiser drains the FIFO at a programmable baud rate. Reads are combinational and side-effect free, because the core samples mem_rdata every cycle regardless of intent.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
DIV_W, 16, width of the baud divisor register.
DEFAULT_DIV, 433, divisor reset value; bit period = DIV+1 clk cycles.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sel  input  1  window selected by the bus decoder
addr  input  4  byte offset in window; only addr[3:2] decoded
wdata  input  32  store data
wenable  input  4  byte-lane write strobes; qualified by sel
rdata  output  32  combinational read data; 0 when !sel
tx  output  1  serial line; idle high
irq  output  1  level: FIFO empty and serialiser idle

Behaviour:
- Reset state: tx=1, irq=1, FIFO empty, overflow=0, divisor=DEFAULT_DIV, FSM=IDLE. Reset applies mid-frame and aborts the frame immediately.
- Register map (addr[3:2]):
  - 0 TXDATA: a write with wenable[0] pushes wdata[7:0]. Reads return 0.
  - 1 STATUS (read): bit0 busy (FSM != IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] count (saturating at 15), other bits 0. A write with wenable[0] and wdata[3]=1 clears overflow.
  - 2 DIVISOR: lanes 0/1 write bytes [7:0]/[15:8]. Reads are zero-extended.
  - 3 reserved: reads 0, writes ignored.
- Push rules:
  - A push when full is dropped and sets overflow.
  - If a push and a pop occur in the same cycle while full, the push is accepted and count is unchanged.
  - A write cycle is a single clk; each asserted cycle is one push.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when FIFO is non-empty, pop the head into the shift register, latch the divisor, and go to START. tx is registered, so tx=0 from that edge.
  - START: after DIV+1 cycles, go to DATA with bit index 0.
  - DATA: tx = shift[0]. Every DIV+1 cycles, shift right and increment index. After 8 bits, go to STOP.
  - STOP: tx=1 for DIV+1 cycles. At the end, if FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing:
  - Baud counter counts 0..latched_div. A divisor write mid-frame takes effect only at the next frame start.
  - DIV=0 gives a 1-cycle bit period and must work.
  - Latency: a push at edge E with FSM IDLE and FIFO empty gives tx low after edge E+1. Frame length = 10*(DIV+1) cycles.
- Pointers: FIFO pointers wrap modulo FIFO_DEPTH. Count is log2(DEPTH)+1 bits wide.
- irq = empty && FSM==IDLE, registered with no extra delay beyond the state registers.

Decomposition:
- Shared package: register offset constants (TXDATA/STATUS/DIVISOR), STATUS bit positions, FSM state encoding, UART frame bit count (8).
- Sub-module: uart_tx_fifo, a synchronous FIFO.
  - Inputs: push, pop, din[7:0].
  - Outputs: dout (head, combinational), full, empty, count.
  - Async reset to empty.
- The top level contains the register decode, the serialiser FSM and the baud counter.

Test Plan:
- Reset then STATUS read -> rdata=0x00000004 (empty=1), tx=1, irq=1, DIVISOR read = 433.
- DIV=3, write 0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy=1 throughout, irq rises 40 cycles after the first low edge.
- DIV=3, write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle cycle between them, count reads 2 after the first pop.
- Hold TX busy, push 9 bytes with DEPTH=8 and FIFO initially empty -> the first byte pops, so all 9 are accepted. A 10th push while full with no pop -> dropped and overflow=1. Write STATUS with wdata=0x8 -> overflow=0.
- Write DIVISOR=1 mid-frame at DIV=3 -> current frame keeps 4-cycle bits, next frame uses 2-cycle bits. Assert rst_n low mid-frame -> tx=1 immediately, FIFO empty, DIVISOR=433.
- Reads with sel=0 or addr[3:2]=3 -> rdata=0. Reading TXDATA does not pop: count is unchanged.
